// File: rtl/mem_access.sv
// Memory-access pipeline stage: runs req/ack data-memory transactions with
// big-endian lane steering and hands a registered bundle to write-back.
module mem_access #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        stall,
    input  logic [31:0] pc,
    input  logic [31:0] insn,
    input  logic [31:0] alu_out,
    input  logic [31:0] rt_val,
    input  logic        dm_we,
    input  logic        r_we,
    input  logic [4:0]  rd_loc,
    input  logic [1:0]  rw_d,
    input  logic [1:0]  mem_read_size,
    input  logic        mem_sign_extend,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_r_we,
    output logic [4:0]  wb_rd_loc,
    output logic [31:0] wb_data,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_insn,
    output logic        misalign_err,
    output logic        bus_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] SZ_WORD  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_BYTE  = 2'd2;
    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    // Encoding 3 is folded onto word so downstream decoders see only 0/1/2.
    function automatic logic [1:0] norm_size(input logic [1:0] sz);
        logic [1:0] r;
        case (sz)
            SZ_HALF: r = SZ_HALF;
            SZ_BYTE: r = SZ_BYTE;
            default: r = SZ_WORD;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] r;
        case (sz)
            SZ_BYTE: r = 4'b1000 >> off;
            SZ_HALF: r = off[1] ? 4'b0011 : 4'b1100;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [1:0] sz, input logic [31:0] rt);
        logic [31:0] r;
        case (sz)
            SZ_BYTE: r = {4{rt[7:0]}};
            SZ_HALF: r = {2{rt[15:0]}};
            default: r = rt;
        endcase
        return r;
    endfunction

    // Big-endian: byte offset 0 is the most significant lane.
    function automatic logic [31:0] load_data(input logic [1:0] sz, input logic sext,
                                              input logic [1:0] off, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = rd[31:24];
            2'd1:    b = rd[23:16];
            2'd2:    b = rd[15:8];
            default: b = rd[7:0];
        endcase
        h = off[1] ? rd[15:0] : rd[31:16];
        case (sz)
            SZ_BYTE: r = {{24{sext & b[7]}}, b};
            SZ_HALF: r = {{16{sext & h[15]}}, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    state_t      state_r, state_nx_s;
    logic [7:0]  cnt_r, cnt_nx_s;
    logic [31:0] pc_r, insn_r;
    logic        r_we_r, sext_r;
    logic [4:0]  rd_loc_r;
    logic [1:0]  size_r, off_r;

    logic        accept_s, mem_op_s, misalign_s, timeout_s, start_s;
    logic [1:0]  size_s;
    logic [31:0] alu_data_s;

    logic        dmem_req_nx_s, dmem_we_nx_s;
    logic [31:0] dmem_addr_nx_s, dmem_wdata_nx_s;
    logic [3:0]  dmem_be_nx_s;
    logic        wb_valid_nx_s, wb_r_we_nx_s, misalign_nx_s, bus_err_nx_s;
    logic [4:0]  wb_rd_loc_nx_s;
    logic [31:0] wb_data_nx_s, wb_pc_nx_s, wb_insn_nx_s;

    assign stall      = (state_r == ST_WAIT);
    assign accept_s   = in_valid & ~stall;
    assign mem_op_s   = dm_we | (rw_d == 2'd1);
    assign size_s     = norm_size(mem_read_size);
    assign misalign_s = ((size_s == SZ_HALF) & alu_out[0]) |
                        ((size_s == SZ_WORD) & (alu_out[1:0] != 2'b00));
    assign timeout_s  = (cnt_r == TMO_LAST);
    assign start_s    = accept_s & mem_op_s & ~misalign_s;
    assign alu_data_s = (rw_d == 2'd2) ? (pc + 32'd8) : alu_out;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; an ack in the timeout cycle still completes normally.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nx_s = ST_WAIT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (dmem_ack || timeout_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Next values of the registered bus and write-back outputs.
    always_comb begin
        cnt_nx_s        = cnt_r;
        dmem_req_nx_s   = dmem_req;
        dmem_we_nx_s    = dmem_we;
        dmem_addr_nx_s  = dmem_addr;
        dmem_be_nx_s    = dmem_be;
        dmem_wdata_nx_s = dmem_wdata;
        wb_valid_nx_s   = 1'b0;
        wb_r_we_nx_s    = wb_r_we;
        wb_rd_loc_nx_s  = wb_rd_loc;
        wb_data_nx_s    = wb_data;
        wb_pc_nx_s      = wb_pc;
        wb_insn_nx_s    = wb_insn;
        misalign_nx_s   = 1'b0;
        bus_err_nx_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_nx_s = 8'd0;
                if (start_s) begin
                    dmem_req_nx_s   = 1'b1;
                    dmem_we_nx_s    = dm_we;
                    dmem_addr_nx_s  = {alu_out[31:2], 2'b00};
                    dmem_be_nx_s    = store_be(size_s, alu_out[1:0]);
                    dmem_wdata_nx_s = store_wdata(size_s, rt_val);
                end else if (accept_s) begin
                    wb_valid_nx_s  = 1'b1;
                    wb_r_we_nx_s   = r_we & ~(mem_op_s & misalign_s);
                    wb_rd_loc_nx_s = rd_loc;
                    wb_data_nx_s   = alu_data_s;
                    wb_pc_nx_s     = pc;
                    wb_insn_nx_s   = insn;
                    misalign_nx_s  = mem_op_s & misalign_s;
                end else begin
                    wb_valid_nx_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (dmem_ack || timeout_s) begin
                    cnt_nx_s       = 8'd0;
                    dmem_req_nx_s  = 1'b0;
                    dmem_we_nx_s   = 1'b0;
                    wb_valid_nx_s  = 1'b1;
                    wb_rd_loc_nx_s = rd_loc_r;
                    wb_pc_nx_s     = pc_r;
                    wb_insn_nx_s   = insn_r;
                    if (dmem_ack) begin
                        wb_r_we_nx_s = r_we_r;
                        wb_data_nx_s = load_data(size_r, sext_r, off_r, dmem_rdata);
                    end else begin
                        wb_r_we_nx_s = 1'b0;
                        wb_data_nx_s = 32'd0;
                        bus_err_nx_s = 1'b1;
                    end
                end else begin
                    cnt_nx_s = cnt_r + 8'd1;
                end
            end
            default: begin
                cnt_nx_s      = 8'd0;
                dmem_req_nx_s = 1'b0;
                dmem_we_nx_s  = 1'b0;
            end
        endcase
    end

    // Output and timeout-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r        <= 8'd0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= 32'd0;
            dmem_be      <= 4'd0;
            dmem_wdata   <= 32'd0;
            wb_valid     <= 1'b0;
            wb_r_we      <= 1'b0;
            wb_rd_loc    <= 5'd0;
            wb_data      <= 32'd0;
            wb_pc        <= 32'd0;
            wb_insn      <= 32'd0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            cnt_r        <= cnt_nx_s;
            dmem_req     <= dmem_req_nx_s;
            dmem_we      <= dmem_we_nx_s;
            dmem_addr    <= dmem_addr_nx_s;
            dmem_be      <= dmem_be_nx_s;
            dmem_wdata   <= dmem_wdata_nx_s;
            wb_valid     <= wb_valid_nx_s;
            wb_r_we      <= wb_r_we_nx_s;
            wb_rd_loc    <= wb_rd_loc_nx_s;
            wb_data      <= wb_data_nx_s;
            wb_pc        <= wb_pc_nx_s;
            wb_insn      <= wb_insn_nx_s;
            misalign_err <= misalign_nx_s;
            bus_err      <= bus_err_nx_s;
        end
    end

    // Bundle fields needed when the memory transaction completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r     <= 32'd0;
            insn_r   <= 32'd0;
            r_we_r   <= 1'b0;
            rd_loc_r <= 5'd0;
            size_r   <= 2'd0;
            sext_r   <= 1'b0;
            off_r    <= 2'd0;
        end else if (start_s) begin
            pc_r     <= pc;
            insn_r   <= insn;
            r_we_r   <= r_we;
            rd_loc_r <= rd_loc;
            size_r   <= size_s;
            sext_r   <= mem_sign_extend;
            off_r    <= alu_out[1:0];
        end else begin
            pc_r     <= pc_r;
            insn_r   <= insn_r;
            r_we_r   <= r_we_r;
            rd_loc_r <= rd_loc_r;
            size_r   <= size_r;
            sext_r   <= sext_r;
            off_r    <= off_r;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: vector table for single-cycle bundles plus
// hand-written load/store, timeout and reset-during-wait sequences.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        stall;
    logic [31:0] pc = 32'd0, insn = 32'd0, alu_out = 32'd0, rt_val = 32'd0;
    logic        dm_we = 1'b0, r_we = 1'b0;
    logic [4:0]  rd_loc = 5'd0;
    logic [1:0]  rw_d = 2'd0, mem_read_size = 2'd0;
    logic        mem_sign_extend = 1'b0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;
    logic        wb_valid, wb_r_we, misalign_err, bus_err;
    logic [4:0]  wb_rd_loc;
    logic [31:0] wb_data, wb_pc, wb_insn;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall),
        .pc(pc), .insn(insn), .alu_out(alu_out), .rt_val(rt_val),
        .dm_we(dm_we), .r_we(r_we), .rd_loc(rd_loc), .rw_d(rw_d),
        .mem_read_size(mem_read_size), .mem_sign_extend(mem_sign_extend),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_r_we(wb_r_we),
        .wb_rd_loc(wb_rd_loc), .wb_data(wb_data), .wb_pc(wb_pc), .wb_insn(wb_insn),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rw_d;
        logic [1:0]  size;
        logic        dm_we;
        logic        r_we;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] exp_data;
        logic        chk_data;
        logic        exp_rwe;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] rwd, input logic [1:0] sz, input logic sx,
                         input logic we, input logic rwe, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] rt, input logic [31:0] p);
        in_valid        = 1'b1;
        rw_d            = rwd;
        mem_read_size   = sz;
        mem_sign_extend = sx;
        dm_we           = we;
        r_we            = rwe;
        rd_loc          = rd;
        alu_out         = alu;
        rt_val          = rt;
        pc              = p;
        insn            = p ^ 32'hA5A5_0000;
    endtask

    // One memory transaction with the ack presented after nwait extra req cycles.
    task automatic mem_txn(input string nm, input logic [1:0] sz, input logic sx,
                           input logic we, input logic rwe, input logic [4:0] rd,
                           input logic [31:0] alu, input logic [31:0] rt,
                           input logic [31:0] rdata, input int nwait,
                           input logic [31:0] e_addr, input logic [3:0] e_be,
                           input logic [31:0] e_wdata, input logic [31:0] e_data);
        @(negedge clk);
        drive(we ? 2'd0 : 2'd1, sz, sx, we, rwe, rd, alu, rt, 32'h0000_1000);
        for (int k = 0; k <= nwait; k++) begin
            @(negedge clk);
            chk({nm, " req"},   {31'd0, dmem_req}, 32'd1);
            chk({nm, " stall"}, {31'd0, stall}, 32'd1);
            chk({nm, " we"},    {31'd0, dmem_we}, {31'd0, we});
            chk({nm, " addr"},  dmem_addr, e_addr);
            chk({nm, " be"},    {28'd0, dmem_be}, {28'd0, e_be});
            chk({nm, " wdata"}, dmem_wdata, e_wdata);
            chk({nm, " early wb_valid"}, {31'd0, wb_valid}, 32'd0);
            if (k == nwait) begin
                in_valid   = 1'b0;
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
        end
        @(negedge clk);
        dmem_ack = 1'b0;
        chk({nm, " wb_valid"}, {31'd0, wb_valid}, 32'd1);
        chk({nm, " wb_r_we"},  {31'd0, wb_r_we}, {31'd0, rwe});
        chk({nm, " wb_rd"},    {27'd0, wb_rd_loc}, {27'd0, rd});
        chk({nm, " wb_pc"},    wb_pc, 32'h0000_1000);
        chk({nm, " bus_err"},  {31'd0, bus_err}, 32'd0);
        chk({nm, " misalign"}, {31'd0, misalign_err}, 32'd0);
        chk({nm, " req drop"}, {31'd0, dmem_req}, 32'd0);
        chk({nm, " stall drop"}, {31'd0, stall}, 32'd0);
        if (!we) chk({nm, " wb_data"}, wb_data, e_data);
    endtask

    initial begin
        int reqs;
        logic done;

        vecs[0] = '{2'd0, 2'd0, 1'b0, 1'b1, 5'd5,  32'h0000_002A, 32'h0000_0100, 32'h0000_002A, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{2'd3, 2'd0, 1'b0, 1'b1, 5'd7,  32'h1234_5678, 32'h0000_0104, 32'h1234_5678, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{2'd2, 2'd0, 1'b0, 1'b1, 5'd31, 32'h0000_0000, 32'h0000_0400, 32'h0000_0408, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{2'd2, 2'd0, 1'b0, 1'b1, 5'd31, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0004, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{2'd1, 2'd0, 1'b0, 1'b1, 5'd8,  32'h0000_3001, 32'h0000_0110, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{2'd1, 2'd1, 1'b0, 1'b1, 5'd9,  32'h0000_3003, 32'h0000_0114, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{2'd0, 2'd0, 1'b1, 1'b0, 5'd0,  32'h0000_3002, 32'h0000_0118, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{2'd1, 2'd3, 1'b0, 1'b1, 5'd10, 32'h0000_0012, 32'h0000_011C, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{2'd0, 2'd0, 1'b0, 1'b0, 5'd11, 32'h0000_0055, 32'h0000_0120, 32'h0000_0055, 1'b1, 1'b0, 1'b0};

        // Reset state.
        #12;
        chk("rst stall",    {31'd0, stall}, 32'd0);
        chk("rst req",      {31'd0, dmem_req}, 32'd0);
        chk("rst wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst addr",     dmem_addr, 32'd0);
        chk("rst wb_data",  wb_data, 32'd0);
        chk("rst errs",     {30'd0, misalign_err, bus_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Ack while idle must not produce anything.
        @(negedge clk);
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("idle ack wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("idle ack stall",    {31'd0, stall}, 32'd0);

        // Back-to-back single-cycle bundles from the table.
        for (int i = 0; i <= 9; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("vec%0d wb_valid", i-1), {31'd0, wb_valid}, 32'd1);
                chk($sformatf("vec%0d wb_rd", i-1),    {27'd0, wb_rd_loc}, {27'd0, vecs[i-1].rd});
                chk($sformatf("vec%0d wb_r_we", i-1),  {31'd0, wb_r_we}, {31'd0, vecs[i-1].exp_rwe});
                chk($sformatf("vec%0d misalign", i-1), {31'd0, misalign_err}, {31'd0, vecs[i-1].exp_mis});
                chk($sformatf("vec%0d bus_err", i-1),  {31'd0, bus_err}, 32'd0);
                chk($sformatf("vec%0d req", i-1),      {31'd0, dmem_req}, 32'd0);
                chk($sformatf("vec%0d stall", i-1),    {31'd0, stall}, 32'd0);
                chk($sformatf("vec%0d wb_pc", i-1),    wb_pc, vecs[i-1].pc);
                chk($sformatf("vec%0d wb_insn", i-1),  wb_insn, vecs[i-1].pc ^ 32'hA5A5_0000);
                if (vecs[i-1].chk_data)
                    chk($sformatf("vec%0d wb_data", i-1), wb_data, vecs[i-1].exp_data);
            end
            if (i < 9)
                drive(vecs[i].rw_d, vecs[i].size, 1'b0, vecs[i].dm_we, vecs[i].r_we,
                      vecs[i].rd, vecs[i].alu, 32'hCAFE_F00D, vecs[i].pc);
            else
                in_valid = 1'b0;
        end

        // wb_* hold when no new bundle arrives.
        @(negedge clk);
        chk("hold wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("hold wb_data",  wb_data, 32'h0000_0055);

        // Loads and stores; lb acks in the timeout cycle, so ack must win.
        mem_txn("lb",  2'd2, 1'b1, 1'b0, 1'b1, 5'd9,  32'h0000_1001, 32'd0, 32'h11F2_3344, 3,
                32'h0000_1000, 4'b0100, 32'h0000_0000, 32'hFFFF_FFF2);
        mem_txn("lbu", 2'd2, 1'b0, 1'b0, 1'b1, 5'd9,  32'h0000_1001, 32'd0, 32'h11F2_3344, 1,
                32'h0000_1000, 4'b0100, 32'h0000_0000, 32'h0000_00F2);
        mem_txn("sh",  2'd1, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0000_2002, 32'hABCD_1234, 32'd0, 2,
                32'h0000_2000, 4'b0011, 32'h1234_1234, 32'd0);
        mem_txn("sb",  2'd2, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0000_5003, 32'h0000_0077, 32'd0, 0,
                32'h0000_5000, 4'b0001, 32'h7777_7777, 32'd0);
        mem_txn("lw",  2'd0, 1'b0, 1'b0, 1'b1, 5'd12, 32'h0000_4000, 32'd0, 32'hDEAD_BEEF, 0,
                32'h0000_4000, 4'b1111, 32'h0000_0000, 32'hDEAD_BEEF);
        mem_txn("lh",  2'd1, 1'b1, 1'b0, 1'b1, 5'd13, 32'h0000_4002, 32'd0, 32'h1234_8001, 1,
                32'h0000_4000, 4'b0011, 32'h0000_0000, 32'hFFFF_8001);
        mem_txn("lhu", 2'd1, 1'b0, 1'b0, 1'b1, 5'd14, 32'h0000_4000, 32'd0, 32'h8001_1234, 0,
                32'h0000_4000, 4'b1100, 32'h0000_0000, 32'h0000_8001);
        mem_txn("lb3", 2'd2, 1'b1, 1'b0, 1'b1, 5'd15, 32'h0000_5003, 32'd0, 32'h0000_0080, 0,
                32'h0000_5000, 4'b0001, 32'h0000_0000, 32'hFFFF_FF80);

        // Timeout: req high for exactly four cycles, then bus_err.
        @(negedge clk);
        drive(2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 5'd16, 32'h0000_6000, 32'd0, 32'h0000_0200);
        reqs = 0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (wb_valid) done = 1'b1;
            else if (dmem_req) reqs++;
        end
        chk("tmo finished", {31'd0, done}, 32'd1);
        chk("tmo req cycles", reqs, 32'd4);
        chk("tmo bus_err", {31'd0, bus_err}, 32'd1);
        chk("tmo wb_r_we", {31'd0, wb_r_we}, 32'd0);
        chk("tmo req drop", {31'd0, dmem_req}, 32'd0);
        chk("tmo stall", {31'd0, stall}, 32'd0);
        drive(2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 5'd17, 32'h0000_0099, 32'd0, 32'h0000_0204);
        @(negedge clk);
        in_valid = 1'b0;
        chk("post-tmo wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("post-tmo wb_data", wb_data, 32'h0000_0099);
        chk("post-tmo bus_err", {31'd0, bus_err}, 32'd0);

        // Reset in the middle of a wait.
        @(negedge clk);
        drive(2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 5'd18, 32'h0000_7000, 32'd0, 32'h0000_0300);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre-rst req", {31'd0, dmem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst req", {31'd0, dmem_req}, 32'd0);
        chk("midrst stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after rst wb_valid", {31'd0, wb_valid}, 32'd0);
        drive(2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 5'd31, 32'd0, 32'd0, 32'h0000_0400);
        @(negedge clk);
        in_valid = 1'b0;
        chk("jal wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("jal wb_data", wb_data, 32'h0000_0408);
        chk("jal wb_rd", {27'd0, wb_rd_loc}, 32'd31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
